// File: rtl/bdc_pkg.sv
// Shared constants for the video pattern generator: pattern codes, bar colours
// and FSM state encoding.
package bdc_pkg;

   typedef enum logic [1:0] {
      PAT_GRID  = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_RAMP  = 2'd3
   } pattern_e;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
   localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] COLOR_RED     = 24'hFF0000;
   localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
   localparam logic [23:0] COLOR_BLACK   = 24'h000000;

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return COLOR_WHITE;
         3'd1:    return COLOR_YELLOW;
         3'd2:    return COLOR_CYAN;
         3'd3:    return COLOR_GREEN;
         3'd4:    return COLOR_MAGENTA;
         3'd5:    return COLOR_RED;
         3'd6:    return COLOR_BLUE;
         default: return COLOR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/axis_pattern_pixel.sv
// Purely combinational pixel function: maps (x, y, pattern, frame count) to an
// RGB888 value.
module axis_pattern_pixel
   import bdc_pkg::*;
#(
   parameter int WIDTH       = 1920,
   parameter int HEIGHT      = 1080,
   parameter int COORD_WIDTH = 16,
   parameter int GRID_PITCH  = 64
) (
   input  logic [COORD_WIDTH-1:0] x,
   input  logic [COORD_WIDTH-1:0] y,
   input  logic [1:0]             pattern,
   input  logic [7:0]             frame_cnt,
   output logic [23:0]            pixel
);

   localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
   localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
   localparam logic [COORD_WIDTH-1:0] PMASK  = COORD_WIDTH'(GRID_PITCH - 1);
   localparam int                     PBIT   = $clog2(GRID_PITCH);

   logic [COORD_WIDTH+2:0] scaled_x;
   logic [2:0]             bar_idx;
   logic                   grid_on;
   logic                   check_on;

   // Divide by a constant so synthesis folds it into a small comparator tree.
   assign scaled_x = {x, 3'b000};
   assign bar_idx  = 3'(scaled_x / (COORD_WIDTH + 3)'(WIDTH));
   assign grid_on  = ((x & PMASK) == '0) || ((y & PMASK) == '0) ||
                     (x == X_LAST) || (y == Y_LAST);
   assign check_on = x[PBIT] ^ y[PBIT];

   always_comb begin
      pixel = COLOR_BLACK;
      case (pattern_e'(pattern))
         PAT_GRID:  pixel = grid_on ? COLOR_WHITE : COLOR_BLACK;
         PAT_BARS:  pixel = bar_color(bar_idx);
         PAT_CHECK: pixel = check_on ? COLOR_WHITE : COLOR_BLACK;
         PAT_RAMP:  pixel = {x[7:0], y[7:0], frame_cnt};
         default:   pixel = COLOR_BLACK;
      endcase
   end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream test pattern source: raster-scans frames with an inter-frame gap,
// all outputs registered.
module axis_video_pattern_gen
   import bdc_pkg::*;
#(
   parameter int WIDTH       = 1920,
   parameter int HEIGHT      = 1080,
   parameter int DATA_WIDTH  = 24,
   parameter int COORD_WIDTH = 16,
   parameter int GRID_PITCH  = 64,
   parameter int FRAME_GAP   = 16,
   parameter int TLAST_EOF   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [1:0]            pattern_sel,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           frame_cnt
);

   localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
   localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
   localparam int                     GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

   logic [1:0]             state_q, state_d;
   logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [1:0]             pat_q, pat_d;
   logic [15:0]            frame_cnt_q, frame_cnt_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;
   logic                   tuser_q, tuser_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;
   logic                   start;
   logic                   active_d;
   logic [23:0]            pix;

   axis_pattern_pixel #(
      .WIDTH      (WIDTH),
      .HEIGHT     (HEIGHT),
      .COORD_WIDTH(COORD_WIDTH),
      .GRID_PITCH (GRID_PITCH)
   ) u_pixel (
      .x        (x_d),
      .y        (y_d),
      .pattern  (pat_d),
      .frame_cnt(frame_cnt_d[7:0]),
      .pixel    (pix)
   );

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      gap_d        = gap_q;
      pat_d        = pat_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      start        = 1'b0;
      case (state_q)
         ST_IDLE: start = enable;
         ST_ACTIVE: begin
            if (tvalid_q && m_axis_tready) begin
               if (x_q == X_LAST && y_q == Y_LAST) begin
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 16'd1;
                  if (FRAME_GAP == 0) begin
                     start   = enable;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_GAP;
                     gap_d   = '0;
                  end
               end else if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               start   = enable;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d = ST_ACTIVE;
         x_d     = '0;
         y_d     = '0;
         pat_d   = pattern_sel;
      end

      // Outputs are precomputed from the next coordinates; a stall leaves x/y unchanged so they hold.
      active_d = (state_d == ST_ACTIVE);
      tvalid_d = active_d;
      busy_d   = active_d;
      tdata_d  = active_d ? DATA_WIDTH'(pix) : '0;
      tuser_d  = active_d && (x_d == '0) && (y_d == '0);
      tlast_d  = active_d && (x_d == X_LAST) && ((TLAST_EOF == 0) || (y_d == Y_LAST));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         gap_q        <= '0;
         pat_q        <= '0;
         frame_cnt_q  <= '0;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         tuser_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         gap_q        <= gap_d;
         pat_q        <= pat_d;
         frame_cnt_q  <= frame_cnt_d;
         tdata_q      <= tdata_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
         tuser_q      <= tuser_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign busy          = busy_q;
   assign frame_done    = frame_done_q;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Self-checking bench: a 16x8 generator with a 3-cycle gap, and a 16x8
// end-of-frame-tlast generator with no gap, against a behavioural pixel model.
module tb_axis_video_pattern_gen;

   logic        clk;
   logic        a_rst_n, a_en, a_tready;
   logic [1:0]  a_sel;
   logic [23:0] a_tdata;
   logic        a_tvalid, a_tlast, a_tuser, a_busy, a_frame_done;
   logic [15:0] a_frame_cnt;
   logic        b_rst_n, b_en, b_tready;
   logic [1:0]  b_sel;
   logic [23:0] b_tdata;
   logic        b_tvalid, b_tlast, b_tuser, b_busy, b_frame_done;
   logic [15:0] b_frame_cnt;

   int          total = 0;
   int          bad   = 0;
   logic [23:0] a_pix [128];
   logic [23:0] b_pix [256];

   axis_video_pattern_gen #(
      .WIDTH(16), .HEIGHT(8), .GRID_PITCH(4), .FRAME_GAP(3), .TLAST_EOF(0)
   ) dut_a (
      .clk(clk), .rst_n(a_rst_n), .enable(a_en), .pattern_sel(a_sel),
      .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
      .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .busy(a_busy),
      .frame_done(a_frame_done), .frame_cnt(a_frame_cnt)
   );

   axis_video_pattern_gen #(
      .WIDTH(16), .HEIGHT(8), .GRID_PITCH(4), .FRAME_GAP(0), .TLAST_EOF(1)
   ) dut_b (
      .clk(clk), .rst_n(b_rst_n), .enable(b_en), .pattern_sel(b_sel),
      .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
      .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .busy(b_busy),
      .frame_done(b_frame_done), .frame_cnt(b_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference pixel for a 16x8 frame with pitch 4.
   function automatic logic [23:0] ref_pix(input int pat, input int x, input int y, input int fc);
      case (pat)
         0: return (x % 4 == 0 || y % 4 == 0 || x == 15 || y == 7) ? 24'hFFFFFF : 24'h000000;
         1: begin
            case ((x * 8) / 16)
               0: return 24'hFFFFFF;
               1: return 24'hFFFF00;
               2: return 24'h00FFFF;
               3: return 24'h00FF00;
               4: return 24'hFF00FF;
               5: return 24'hFF0000;
               6: return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         2: return (((x / 4) % 2) != ((y / 4) % 2)) ? 24'hFFFFFF : 24'h000000;
         default: return 24'((x % 256) * 65536 + (y % 256) * 256 + (fc % 256));
      endcase
   endfunction

   // Consume up to stop_at beats from dut_a, checking every accepted beat and every stall.
   task automatic collect_a(input int pat, input int fc, input bit rnd, input int drop_at,
                            input int sel_at, input logic [1:0] new_sel, input int stop_at);
      int          acc = 0;
      int          cyc = 0;
      bit          started = 0;
      bit          stalled = 0;
      logic [25:0] held = '0;
      while (acc < stop_at && cyc < 2000) begin
         if (a_tvalid) begin
            started = 1;
            if (stalled) check("stall_hold", {6'd0, a_tuser, a_tlast, a_tdata}, {6'd0, held});
            if (acc == drop_at) a_en = 1'b0;
            if (acc == sel_at) a_sel = new_sel;
            a_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_tready) begin
               check("a_pixel", {8'd0, a_tdata}, {8'd0, ref_pix(pat, acc % 16, acc / 16, fc)});
               check("a_tuser", {31'd0, a_tuser}, {31'd0, acc == 0});
               check("a_tlast", {31'd0, a_tlast}, {31'd0, acc % 16 == 15});
               check("a_busy", {31'd0, a_busy}, 32'd1);
               a_pix[acc] = a_tdata;
               acc++;
               stalled = 0;
            end else begin
               stalled = 1;
               held = {a_tuser, a_tlast, a_tdata};
            end
         end else begin
            if (started) check("a_no_bubble", {31'd0, a_tvalid}, 32'd1);
            a_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         wait_cycle();
         cyc++;
      end
      a_tready = 1'b1;
      check("a_beat_count", acc, stop_at);
      $display("frame a pat=%0d beats=%0d cycles=%0d frame_cnt=%0d", pat, acc, cyc, a_frame_cnt);
   endtask

   // Count idle cycles after a frame until the next tuser.
   task automatic gap_a(input int exp_idle);
      int idle = 0;
      while (!a_tvalid && idle < 20) begin
         if (idle > 0) check("a_done_once", {31'd0, a_frame_done}, 32'd0);
         check("a_gap_busy", {31'd0, a_busy}, 32'd0);
         idle++;
         wait_cycle();
      end
      check("a_gap_len", idle, exp_idle);
      check("a_next_tuser", {31'd0, a_tuser}, 32'd1);
   endtask

   initial begin
      int n;
      int cyc;
      a_rst_n = 1'b0; a_en = 1'b0; a_sel = 2'd0; a_tready = 1'b1;
      b_rst_n = 1'b0; b_en = 1'b0; b_sel = 2'd0; b_tready = 1'b1;
      repeat (3) wait_cycle();

      check("rst_tvalid", {31'd0, a_tvalid}, 32'd0);
      check("rst_tdata", {8'd0, a_tdata}, 32'd0);
      check("rst_tlast", {31'd0, a_tlast}, 32'd0);
      check("rst_tuser", {31'd0, a_tuser}, 32'd0);
      check("rst_busy", {31'd0, a_busy}, 32'd0);
      check("rst_done", {31'd0, a_frame_done}, 32'd0);
      check("rst_fcnt", {16'd0, a_frame_cnt}, 32'd0);

      // Grid frame, full throughput.
      a_rst_n = 1'b1; a_en = 1'b1; a_sel = 2'd0;
      wait_cycle();
      check("first_tvalid", {31'd0, a_tvalid}, 32'd1);
      collect_a(0, 0, 1'b0, -1, -1, 2'd0, 128);
      check("grid_0_0", {8'd0, a_pix[0]}, 32'hFFFFFF);
      check("grid_5_4", {8'd0, a_pix[69]}, 32'hFFFFFF);
      check("grid_15_3", {8'd0, a_pix[63]}, 32'hFFFFFF);
      check("grid_5_5", {8'd0, a_pix[85]}, 32'h000000);
      check("f1_done", {31'd0, a_frame_done}, 32'd1);
      check("f1_fcnt", {16'd0, a_frame_cnt}, 32'd1);
      a_sel = 2'd1;
      gap_a(3);

      // Colour bars.
      collect_a(1, 1, 1'b0, -1, -1, 2'd0, 128);
      check("bars_x2", {8'd0, a_pix[2]}, 32'hFFFF00);
      check("bars_x15", {8'd0, a_pix[15]}, 32'h000000);
      check("f2_fcnt", {16'd0, a_frame_cnt}, 32'd2);
      a_sel = 2'd2;
      gap_a(3);

      // Checker with random backpressure.
      collect_a(2, 2, 1'b1, -1, -1, 2'd0, 128);
      check("f3_fcnt", {16'd0, a_frame_cnt}, 32'd3);

      // Reset in the gap, then drop enable and change pattern mid-frame.
      a_rst_n = 1'b0;
      wait_cycle();
      a_rst_n = 1'b1; a_sel = 2'd0;
      collect_a(0, 0, 1'b0, 40, 50, 2'd3, 128);
      check("drop_done", {31'd0, a_frame_done}, 32'd1);
      check("drop_fcnt", {16'd0, a_frame_cnt}, 32'd1);
      wait_cycle();
      for (int i = 0; i < 8; i++) begin
         check("drop_idle_valid", {31'd0, a_tvalid}, 32'd0);
         check("drop_idle_done", {31'd0, a_frame_done}, 32'd0);
         wait_cycle();
      end
      check("drop_idle_busy", {31'd0, a_busy}, 32'd0);
      check("drop_fcnt_hold", {16'd0, a_frame_cnt}, 32'd1);

      // Reset at beat 70 aborts the frame.
      a_sel = 2'd0; a_en = 1'b1;
      collect_a(0, 1, 1'b0, -1, -1, 2'd0, 70);
      a_rst_n = 1'b0;
      wait_cycle();
      check("abort_tvalid", {31'd0, a_tvalid}, 32'd0);
      check("abort_fcnt", {16'd0, a_frame_cnt}, 32'd0);
      check("abort_tuser", {31'd0, a_tuser}, 32'd0);
      a_rst_n = 1'b1;
      wait_cycle();
      check("restart_tvalid", {31'd0, a_tvalid}, 32'd1);
      check("restart_tuser", {31'd0, a_tuser}, 32'd1);
      collect_a(0, 0, 1'b0, -1, -1, 2'd0, 128);
      a_en = 1'b0;

      // End-of-frame tlast, no gap, ramp pattern, two frames.
      b_rst_n = 1'b1; b_en = 1'b1; b_sel = 2'd3; b_tready = 1'b1;
      wait_cycle();
      n = 0;
      cyc = 0;
      while (n < 256 && cyc < 600) begin
         check("b_valid", {31'd0, b_tvalid}, 32'd1);
         if (b_tvalid) begin
            check("b_pixel", {8'd0, b_tdata}, {8'd0, ref_pix(3, n % 16, (n / 16) % 8, n / 128)});
            check("b_tuser", {31'd0, b_tuser}, {31'd0, n % 128 == 0});
            check("b_tlast", {31'd0, b_tlast}, {31'd0, n % 128 == 127});
            b_pix[n] = b_tdata;
            n++;
         end
         wait_cycle();
         cyc++;
      end
      b_en = 1'b0;
      check("b_beats", n, 256);
      check("b_beat128_blue", {24'd0, b_pix[128][7:0]}, 32'h01);
      check("b_fcnt", {16'd0, b_frame_cnt}, 32'd2);
      $display("frame b pat=3 beats=%0d cycles=%0d frame_cnt=%0d", n, cyc, b_frame_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_video_pattern_gen.md
AXIS_VIDEO_PATTERN_GEN -- requirements
Module: axis_video_pattern_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 1920: active pixels per line.
- HEIGHT, 1080: lines per frame.
- DATA_WIDTH, 24: RGB888; R in [23:16], G in [15:8], B in [7:0]; only 24 is supported.
- COORD_WIDTH, 16: x/y counter width.
- GRID_PITCH, 64: grid/checker pitch; power of two, at least 2.
- FRAME_GAP, 16: idle cycles between frames; 0 is allowed.
- TLAST_EOF, 0: 0 = tlast marks end of line; 1 = tlast marks end of frame only.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, synchronous, active-low.
- enable, in, 1: run request.
- pattern_sel, in, 2: pattern code.
- m_axis_tdata, out, DATA_WIDTH: pixel.
- m_axis_tvalid, out, 1.
- m_axis_tready, in, 1.
- m_axis_tlast, out, 1.
- m_axis_tuser, out, 1: start of frame (SOF).
- busy, out, 1: high while a frame is in flight.
- frame_done, out, 1: one-cycle pulse.
- frame_cnt, out, 16: completed frames, wraps.

Function
REQ-003 FSM states SHALL be IDLE, ACTIVE and GAP:
- IDLE->ACTIVE when enable=1.
- ACTIVE->GAP on acceptance of the last pixel (x=WIDTH-1, y=HEIGHT-1).
- GAP->ACTIVE after FRAME_GAP cycles if enable=1, else GAP->IDLE.
- With FRAME_GAP=0, GAP SHALL last zero cycles: ACTIVE is followed directly by ACTIVE or IDLE.
REQ-004 The first tvalid SHALL assert the cycle after enable is sampled high in IDLE, carrying pixel (0,0) with tuser=1.
REQ-005 A beat is accepted when tvalid and tready are both 1. While tvalid=1 and tready=0, tdata/tlast/tuser SHALL hold stable.
REQ-006 Pixels SHALL be emitted in raster order, with x wrapping at WIDTH-1 and y incrementing. Back-to-back beats SHALL be sent with no bubbles while tready=1 in ACTIVE.
REQ-007 tuser SHALL be 1 only on pixel (0,0).
REQ-008 tlast placement:
- TLAST_EOF=0: tlast=1 on every x=WIDTH-1.
- TLAST_EOF=1: tlast=1 only on (WIDTH-1, HEIGHT-1).
REQ-009 pattern_sel SHALL be latched at frame start (IDLE/GAP->ACTIVE). Changes mid-frame SHALL have no effect until the next frame.
REQ-010 Pattern 0 (grid): pixel is FFFFFF if x%GRID_PITCH==0, y%GRID_PITCH==0, x==WIDTH-1 or y==HEIGHT-1; otherwise 000000.
REQ-011 Pattern 1 (colour bars): bar index = x*8/WIDTH, computed with an integer divide by a constant. Bars 0..7 SHALL be FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-012 Pattern 2 (checker): FFFFFF when bit log2(GRID_PITCH) of x XOR the same bit of y is 1; otherwise 000000.
REQ-013 Pattern 3 (ramp): R=x[7:0], G=y[7:0], B=frame_cnt[7:0].
REQ-014 Deasserting enable mid-frame SHALL NOT truncate the frame. The frame completes, then GAP, then IDLE.
REQ-015 frame_done SHALL pulse for one cycle the cycle after the last pixel of a frame is accepted. frame_cnt SHALL increment in that same cycle and wrap FFFF->0000.
REQ-016 busy SHALL be 1 in ACTIVE and 0 in IDLE and GAP.
REQ-017 tvalid SHALL be 0 in IDLE and GAP.
REQ-018 All outputs SHALL be registered; there is no combinational path from tready or enable to any output.

Reset
REQ-019 While rst_n=0 at a clk edge, the block SHALL reset to: state IDLE, x=y=0, tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, frame_done=0, frame_cnt=0, latched pattern=0.
REQ-020 A reset asserted mid-frame SHALL abort the frame with no further beats. The first frame after reset release SHALL restart at (0,0) with tuser=1.

Structure
REQ-021 Pattern codes (PAT_GRID=0, PAT_BARS=1, PAT_CHECK=2, PAT_RAMP=3), the eight 24-bit bar colour constants and the FSM state encoding SHALL live in the shared package bdc_pkg.
REQ-022 The pixel function SHALL be a purely combinational sub-module, axis_pattern_pixel, with inputs x, y, pattern and frame_cnt and output pixel. The top level holds the FSM, counters and output registers.

Verification
All scenarios use WIDTH=16, HEIGHT=8, GRID_PITCH=4, FRAME_GAP=3 unless stated otherwise.
REQ-023 Reset, enable=1, pattern 0, tready=1: exactly 128 beats with no bubbles. Pixels (0,0), (5,4) and (15,3) are FFFFFF; pixel (5,5) is 000000. tuser is high on beat 0 only. tlast is high on beats 15, 31, ..., 127. After the last beat, 3 idle cycles precede the next tuser.
REQ-024 Pattern 1 with tready=1: beats at x=0..15 carry bars 0..7 in pairs; x=2 is FFFF00 and x=15 is 000000.
REQ-025 Random tready at 50%: every stalled beat holds tdata/tlast/tuser stable; total accepted beats is 128; pixel values match a reference model.
REQ-026 Drop enable at beat 40 and change pattern_sel to 3 at beat 50: the frame still completes with 128 pattern-0 beats; frame_done pulses once; frame_cnt=1; then the block returns to IDLE with tvalid=0.
REQ-027 Assert rst_n=0 for 1 cycle at beat 70: tvalid=0 the next cycle and frame_cnt=0. With enable=1 held, the next beat is (0,0) with tuser=1.
REQ-028 TLAST_EOF=1, FRAME_GAP=0, pattern 3, 2 frames: tlast only on beats 127 and 255; beat 128 has tuser=1 with no gap cycle; beat 128 B=01.
